// File: rtl/pwm_drv.sv
// pwm_drv: 12-bit PWM driver with shadowed duty loading and complementary gate drives.
// Define PWM_DEADTIME_EN to build the dead-time FSM; otherwise the gates follow raw directly.
module pwm_drv #(
    parameter int unsigned DEAD_CYC = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] drv_duty,
    input  logic        duty_vld,
    input  logic        en,
    output logic        PWM_hi,
    output logic        PWM_lo,
    output logic        cycle_start,
    output logic [11:0] duty_act
);

    localparam logic [11:0] CNT_MAX = 12'hFFF;

    if (DEAD_CYC < 1 || DEAD_CYC > 255) begin : g_dead_range
        $error("pwm_drv: DEAD_CYC must be in 1..255");
    end

    logic [11:0] cnt;
    logic [11:0] shadow;
    logic        pending;
    logic        raw;
    logic        period_end;

    assign period_end  = en && (cnt == CNT_MAX);
    assign cycle_start = en && !rst && (cnt == 12'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 12'd1;
        end else begin
            cnt <= '0;
        end
    end

    // A request arriving on the last clock of a period bypasses the shadow and lands directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            pending  <= 1'b0;
            duty_act <= '0;
        end else begin
            if (duty_vld) begin
                shadow <= drv_duty;
            end
            if (period_end) begin
                if (duty_vld) begin
                    duty_act <= drv_duty;
                end else if (pending) begin
                    duty_act <= shadow;
                end
                pending <= 1'b0;
            end else if (!en && pending) begin
                duty_act <= shadow;
                pending  <= duty_vld;
            end else if (duty_vld) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raw <= 1'b0;
        end else begin
            raw <= (cnt < duty_act);
        end
    end

`ifdef PWM_DEADTIME_EN
    typedef enum logic [2:0] {
        IDLE,
        LO,
        DEAD_TO_HI,
        HI,
        DEAD_TO_LO
    } state_t;

    localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYC - 1);

    state_t     state;
    logic [7:0] dead_cnt;

    // Outputs are registered alongside the state so each gate equals its state's drive.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            state    <= IDLE;
            dead_cnt <= '0;
            PWM_hi   <= 1'b0;
            PWM_lo   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state    <= DEAD_TO_LO;
                    dead_cnt <= '0;
                    PWM_hi   <= 1'b0;
                    PWM_lo   <= 1'b0;
                end
                LO: begin
                    if (raw) begin
                        state    <= DEAD_TO_HI;
                        dead_cnt <= '0;
                        PWM_lo   <= 1'b0;
                    end
                end
                DEAD_TO_HI: begin
                    if (!raw) begin
                        state  <= LO;
                        PWM_lo <= 1'b1;
                    end else if (dead_cnt >= DEAD_LAST) begin
                        state  <= HI;
                        PWM_hi <= 1'b1;
                    end else begin
                        dead_cnt <= dead_cnt + 8'd1;
                    end
                end
                HI: begin
                    if (!raw) begin
                        state    <= DEAD_TO_LO;
                        dead_cnt <= '0;
                        PWM_hi   <= 1'b0;
                    end
                end
                DEAD_TO_LO: begin
                    if (raw) begin
                        state  <= HI;
                        PWM_hi <= 1'b1;
                    end else if (dead_cnt >= DEAD_LAST) begin
                        state  <= LO;
                        PWM_lo <= 1'b1;
                    end else begin
                        dead_cnt <= dead_cnt + 8'd1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    dead_cnt <= '0;
                    PWM_hi   <= 1'b0;
                    PWM_lo   <= 1'b0;
                end
            endcase
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            PWM_hi <= 1'b0;
            PWM_lo <= 1'b0;
        end else begin
            PWM_hi <= en && raw;
            PWM_lo <= en && !raw;
        end
    end
`endif

endmodule

// File: doc/pwm_drv.md
PWM_DRV -- requirements
Module: pwm_drv

Interface
REQ-001 Parameter DEAD_CYC, default 32, is the dead-time length in clocks, range 1..255.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 drv_duty  input  12  unsigned duty request from the PID controller; 0 = 0%, 4095 = 4095/4096.
REQ-005 duty_vld  input  1  load strobe; drv_duty is captured on every clk where duty_vld=1.
REQ-006 en  input  1  run enable; 0 = outputs off, counter held.
REQ-007 PWM_hi  output  1  high-side gate drive, registered.
REQ-008 PWM_lo  output  1  low-side gate drive, registered, complementary to PWM_hi.
REQ-009 cycle_start  output  1  one-clock pulse marking the first clock of each PWM period.
REQ-010 duty_act  output  12  duty value currently applied to the period counter.

Function
REQ-011 The 12-bit period counter cnt SHALL increment by 1 per clk while en=1, wrapping from 4095 to 0 (period = 4096 clks), and SHALL be held at 0 while en=0.
REQ-012 The shadow register SHALL load drv_duty when duty_vld=1 and set the pending flag.
REQ-013 When en=1 and cnt=4095 with pending=1, duty_act SHALL load the shadow value and clear pending; duty_act SHALL never change mid-period.
REQ-014 If duty_vld=1 in the cnt=4095 cycle, the incoming drv_duty SHALL be the value applied to the next period, and pending SHALL end cleared.
REQ-015 While en=0, duty_act SHALL load the shadow value whenever pending=1.
REQ-016 Registered raw SHALL equal (cnt < duty_act): duty 0 gives raw never high, and duty 4095 gives raw low for exactly 1 clk per period.
REQ-017 cycle_start SHALL be 1 for exactly the clk in which cnt=0 and en=1.
REQ-018 The output FSM SHALL have states IDLE (both low), LO (PWM_lo=1), DEAD_TO_HI (both low), HI (PWM_hi=1) and DEAD_TO_LO (both low).
REQ-019 FSM transitions:
- IDLE to DEAD_TO_LO on en=1.
- LO to DEAD_TO_HI on raw=1.
- DEAD_TO_HI to HI after DEAD_CYC clks; to LO immediately if raw=0 before expiry.
- HI to DEAD_TO_LO on raw=0.
- DEAD_TO_LO to LO after DEAD_CYC clks; to HI immediately if raw=1 before expiry.
- Any state to IDLE on en=0 (outputs low in the next clk).
REQ-020 The dead-time counter SHALL be 8 bits, clear on entry to either DEAD state, and never wrap.
REQ-021 PWM_hi and PWM_lo SHALL never be 1 in the same clk, under any input sequence.
REQ-022 When the raw high pulse is at most DEAD_CYC clks, PWM_hi SHALL stay 0 for that period and PWM_lo SHALL resume with no glitch.

Reset
REQ-023 With rst=1 at a clk edge, the following SHALL be cleared: cnt=0, shadow=0, pending=0, duty_act=0, raw=0, state=IDLE, PWM_hi=0, PWM_lo=0, cycle_start=0. Reset takes priority over en and duty_vld.
REQ-024 Reset asserted mid-period SHALL force both outputs low at the next edge, and a pending duty SHALL be discarded.

Configuration
REQ-025 Macro PWM_DEADTIME_EN defined: dead-time FSM per REQ-018..022 is compiled in.
REQ-026 Macro PWM_DEADTIME_EN undefined: the FSM and dead-time counter are removed. PWM_hi = en & raw, and PWM_lo = en & ~raw, both registered one clk after raw. All other requirements are unchanged.

Verification
REQ-027 Reset release, en=1, no duty_vld -> duty_act=0, PWM_hi never 1, PWM_lo=1 from DEAD_CYC clks after IDLE exit, cycle_start every 4096 clks.
REQ-028 duty_vld with drv_duty=12'h800 at cnt=100 -> duty_act stays 0 until the wrap, then 12'h800. Next period: PWM_hi high for 2048-DEAD_CYC clks and PWM_lo low for 2048+DEAD_CYC clks.
REQ-029 duty_vld with drv_duty=12'h010 in the cnt=4095 cycle, DEAD_CYC=32 -> next period duty_act=16, raw 16 clks wide, PWM_hi stays 0, and PWM_lo drops and recovers within 16 clks.
REQ-030 drv_duty=4095, then drv_duty=0 -> both outputs are checked every clk and never high together. With duty 0, PWM_lo is constant 1 after dead time.
REQ-031 rst pulse for one clk at cnt=2000 with PWM_hi=1 -> next clk PWM_hi=0, PWM_lo=0, cnt=0 and duty_act=0.
REQ-032 en dropped for 10 clks mid-period, with duty_vld for 12'h300 during that time -> outputs low, cnt=0 and duty_act=12'h300 while en=0. On en rise, cnt restarts at 0 and cycle_start pulses.
